// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op decode helpers keep the signedness rules in one place.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 shared multiply/divide datapath: sign-magnitude prep, one bit per
// CALC cycle (shift-add or restoring divide), sign fix-up on entry to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(CYCLES);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_PREP = ST_PREP;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_t      op_q, op_d;
  logic [4:0]      rd_cap_q, rd_cap_d;
  logic [XLEN-1:0] hi_q, hi_d;     // product high word / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // raw a, then multiplier / dividend-quotient
  logic [XLEN-1:0] opb_q, opb_d;   // raw b, then multiplicand / divisor magnitude
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // One iteration of the shared datapath.
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    step_hi  = hi_q;
    step_lo  = lo_q;
    if (op_is_div(op_q)) begin
      if (!rem_diff[XLEN]) begin
        step_hi = rem_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and word select, computed from the final iteration's outputs
  // so the registered result lands exactly on the edge entering DONE.
  logic [2*XLEN-1:0] prod_abs, prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, calc_result;

  always_comb begin
    prod_abs = {step_hi, step_lo};
    prod_fin = neg_q ? -prod_abs : prod_abs;
    quo_fin  = neg_q ? -step_lo : step_lo;
    rem_fin  = rem_neg_q ? -step_hi : step_hi;
    case (op_q)
      OP_MUL:                      calc_result = prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             calc_result = quo_fin;
      default:                     calc_result = rem_fin;
    endcase
  end

  // Operand preparation; lo_q/opb_q still hold the raw captured operands.
  logic            a_neg, b_neg, div_zero, div_ovf, div_special;
  logic [XLEN-1:0] mag_a, mag_b, special_result;

  always_comb begin
    a_neg       = op_a_signed(op_q) & lo_q[XLEN-1];
    b_neg       = op_b_signed(op_q) & opb_q[XLEN-1];
    mag_a       = a_neg ? -lo_q : lo_q;
    mag_b       = b_neg ? -opb_q : opb_q;
    div_zero    = op_is_div(op_q) && (opb_q == '0);
    div_ovf     = op_is_div(op_q) && !op_q[0] && (lo_q == INT_MIN) && (opb_q == '1);
    div_special = div_zero || div_ovf;
    if (div_zero) special_result = op_is_rem(op_q) ? lo_q : DIV0_Q;
    else          special_result = op_is_rem(op_q) ? '0 : INT_MIN;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_cap_d  = rd_cap_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = muldiv_op_t'(funct3);
          rd_cap_d = rd_in;
          lo_d     = a;
          opb_d    = b;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        if (div_special) begin
          result_d = special_result;
          rd_out_d = rd_cap_q;
          state_d  = S_DONE;
        end else begin
          hi_d      = '0;
          lo_d      = mag_a;
          opb_d     = mag_b;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          result_d = calc_result;
          rd_out_d = rd_cap_q;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      rd_cap_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_cap_q  <= rd_cap_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// multi-cycle sequences, and random ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec  = 0;
  int n_miss = 0;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    int          sx, sy;
    longint      sp;
    logic [63:0] up;
    sx = x;
    sy = y;
    case (f)
      3'd0: begin up = 64'(x) * 64'(y); return up[31:0]; end
      3'd1: begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
      3'd2: begin sp = longint'(sx) * longint'({32'b0, y}); return sp[63:32]; end
      3'd3: begin up = 64'(x) * 64'(y); return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op from IDLE and waits (bounded) for done; cycle 1 is PREP.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output bit busy_ok, output bit hold_ok);
    logic [31:0] prev;
    int          cyc;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    prev   = result;
    start  = 1'b1;
    funct3 = f;
    a      = x;
    b      = y;
    rd_in  = rd;
    @(negedge clk);
    cyc     = 1;
    start   = 1'b0;
    funct3  = 3'($urandom);
    a       = $urandom;
    b       = $urandom;
    rd_in   = 5'($urandom);
    busy_ok = busy;
    hold_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (result !== prev) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (!busy) busy_ok = 1'b0;
    end
    lat = done ? cyc : -1;
    res = result;
    rdo = rd_out;
  endtask

  task automatic apply(input string nm, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    bit          busy_ok, hold_ok;
    run_op(f, x, y, rd, res, rdo, lat, busy_ok, hold_ok);
    check({nm, "_result"}, res, exp);
    check({nm, "_rd_out"}, 32'(rdo), 32'(rd));
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_busy"}, 32'(busy_ok), 32'd1);
    check({nm, "_hold"}, 32'(hold_ok), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int          cyc, ndone, d1_at, d2_at;
    logic [31:0] r1, r2;
    logic [4:0]  rd1, rd2;
    bit          busy_after, rst_ok;

    vecs.push_back('{"mul_7x6",       3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         34});
    vecs.push_back('{"mulh_m1",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  34});
    vecs.push_back('{"mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFF,  34});
    vecs.push_back('{"mulhu_m1",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFE,  34});
    vecs.push_back('{"mulh_min_min",  3'd1, 32'h8000_0000,  32'h8000_0000,  5'd4,  32'h4000_0000,  34});
    vecs.push_back('{"mul_min_m1",    3'd0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000,  34});
    vecs.push_back('{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  34});
    vecs.push_back('{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  34});
    vecs.push_back('{"divu_m7_2",     3'd5, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'h7FFF_FFFC,  34});
    vecs.push_back('{"remu_m7_2",     3'd7, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'h0000_0001,  34});
    vecs.push_back('{"div_7_m2",      3'd4, 32'd7,          32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD,  34});
    vecs.push_back('{"rem_7_m2",      3'd6, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'h0000_0001,  34});
    vecs.push_back('{"divu_123_0",    3'd5, 32'd123,        32'd0,          5'd13, 32'hFFFF_FFFF,  2});
    vecs.push_back('{"rem_123_0",     3'd6, 32'd123,        32'd0,          5'd14, 32'd123,        2});
    vecs.push_back('{"div_m7_0",      3'd4, 32'hFFFF_FFF9,  32'd0,          5'd15, 32'hFFFF_FFFF,  2});
    vecs.push_back('{"remu_m7_0",     3'd7, 32'hFFFF_FFF9,  32'd0,          5'd16, 32'hFFFF_FFF9,  2});
    vecs.push_back('{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  2});
    vecs.push_back('{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'h0000_0000,  2});
    vecs.push_back('{"divu_min_m1",   3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 32'h0000_0000,  34});

    reset  = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    a      = '0;
    b      = '0;
    rd_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    reset = 1'b0;

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // start during CALC is ignored; next start right after DONE is accepted
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd7; b = 32'd6; rd_in = 5'd5;
    cyc = 0; ndone = 0; d1_at = -1; d2_at = -1; r1 = '0; r2 = '0; rd1 = '0; rd2 = '0;
    while (cyc < 75) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (d1_at < 0) begin d1_at = cyc; r1 = result; rd1 = rd_out; end
        else if (d2_at < 0) begin d2_at = cyc; r2 = result; rd2 = rd_out; end
      end
      start = (cyc == 10 || cyc == 35);
      if (cyc == 10) begin funct3 = 3'd3; a = 32'd3; b = 32'd3; rd_in = 5'd9; end
      if (cyc == 35) begin funct3 = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd12; end
    end
    check("b2b_first_done_at",  32'(d1_at), 32'd34);
    check("b2b_first_result",   r1,          32'd42);
    check("b2b_first_rd",       32'(rd1),    32'd5);
    check("b2b_second_done_at", 32'(d2_at), 32'd69);
    check("b2b_second_result",  r2,          32'd14);
    check("b2b_second_rd",      32'(rd2),    32'd12);
    check("b2b_done_count",     32'(ndone),  32'd2);

    // start asserted only during the DONE cycle of a special-case divide is lost
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd123; b = 32'd0; rd_in = 5'd3;
    cyc = 0; ndone = 0; d1_at = -1; busy_after = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin ndone++; if (d1_at < 0) d1_at = cyc; end
      if (cyc > 2 && busy) busy_after = 1'b1;
      start = (cyc == 2);
      if (cyc == 2) begin funct3 = 3'd0; a = 32'd2; b = 32'd3; rd_in = 5'd4; end
    end
    check("lost_start_done_at",   32'(d1_at),      32'd2);
    check("lost_start_done_cnt",  32'(ndone),      32'd1);
    check("lost_start_busy",      32'(busy_after), 32'd0);
    check("lost_start_result",    result,          32'hFFFF_FFFF);

    // reset mid-CALC aborts the op with no done pulse
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd7; b = 32'd6; rd_in = 5'd5;
    cyc = 0; ndone = 0; rst_ok = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) ndone++;
      if (cyc == 21) begin
        rst_ok = !busy && !done && (result == 32'd0) && (rd_out == 5'd0);
        reset  = 1'b0;
      end
      if (cyc == 20) reset = 1'b1;
    end
    check("reset_mid_outputs", 32'(rst_ok), 32'd1);
    check("reset_mid_no_done", 32'(ndone),  32'd0);
    check("reset_mid_idle",    32'(busy),   32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      logic [4:0]  rd;
      f  = 3'($urandom_range(0, 7));
      x  = pick();
      y  = pick();
      rd = 5'($urandom);
      apply($sformatf("rand%0d_f%0d_%h_%h", i, f, x, y), f, x, y, rd, model(f, x, y), model_lat(f, x, y));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
